craps_round_ctrl: RTL and testbench
===================================

// Module: craps_round_ctrl
// PURPOSE
//  Parametrised successor to the craps game controller. Sequences a full game: come-out roll,
//  point save, point rolls. Talks to the dice/compare datapath through a roll_req/roll_done handshake.
//  Adds a point-roll limit, restart without reset, and saturating win/lose statistics.
//  Sits between the user "enter" button and the dice roller / point register / comparator.
// PARAMETERS
//  CNT_W           8  width of win/lose/streak counters (saturating)
//  ROLLS_W         4  width of point-roll counter
//  MAX_POINT_ROLLS 0  point rolls allowed before forced LOSE; 0 = unlimited; must be < 2**ROLLS_W
//  AUTO_RESTART    1  1: enter edge in WIN/LOSE starts a new game; 0: only reset leaves WIN/LOSE
// PORTS
//  clk_main    in   1        system clock, rising edge
//  reset       in   1        asynchronous, active-high
//  enter       in   1        user button, level (debounced upstream); rising edge detected internally
//  roll_done   in   1        dice result valid this cycle; flags below are sampled only then
//  natural     in   1        come-out sum is 7 or 11
//  craps       in   1        come-out sum is 2, 3 or 12
//  seven_out   in   1        point-phase sum is 7
//  eq          in   1        point-phase sum equals saved point
//  roll        out  1        roll request; held high until roll_done
//  sp          out  1        save-point strobe; 1 cycle, point register loads current sum
//  win         out  1        level, high while in WIN
//  lose        out  1        level, high while in LOSE
//  busy        out  1        high in any state except IDLE/POINT_WAIT/WIN/LOSE
//  point_rolls out  ROLLS_W  point rolls taken this game
//  win_cnt     out  CNT_W    games won since reset
//  lose_cnt    out  CNT_W    games lost since reset
//  streak      out  CNT_W    consecutive wins (0 when CRAPS_STREAK_EN undefined)
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; counters 0; enter edge register cleared.
//  enter_rise = enter & ~enter_q. Only enter_rise advances the FSM. Held enter never retriggers.
//  IDLE       -enter_rise->           COME_ROLL
//  COME_ROLL  roll=1. On roll_done: natural->WIN; else craps->LOSE; else SAVE.
//             natural has priority if natural & craps are both high.
//  SAVE       sp=1 for exactly 1 cycle; point_rolls<=0 -> POINT_WAIT
//  POINT_WAIT -enter_rise->           POINT_ROLL
//  POINT_ROLL roll=1. On roll_done: point_rolls+1 (saturating).
//             eq->WIN; else seven_out->LOSE; else limit hit (MAX_POINT_ROLLS!=0 and new count==MAX)->LOSE;
//             else POINT_WAIT. eq has priority over seven_out.
//  WIN/LOSE   Outputs held. Counter increments once on entry.
//             With AUTO_RESTART=1, enter_rise -> COME_ROLL, point_rolls<=0, win/lose drop next cycle.
//  Latency: enter_rise -> roll high next cycle. roll_done -> win/lose/sp/roll-drop next cycle.
//  roll_done outside COME_ROLL/POINT_ROLL is ignored. enter_rise while roll=1 is ignored.
//  win and lose are never both high. roll never high in WIN/LOSE/IDLE.
//  Counters saturate at 2**CNT_W-1 and never wrap.
//  Reset mid-roll aborts with no counter update. A pending roll_done after reset is ignored.
// CONFIGURATION
//  CRAPS_STREAK_EN defined: streak +1 (saturating) on WIN entry, cleared to 0 on LOSE entry.
//  CRAPS_STREAK_EN undefined: streak tied to 0, no streak logic. Port list is unchanged.
// STRUCTURE
//  craps_pkg: state enum (IDLE, COME_ROLL, SAVE, POINT_WAIT, POINT_ROLL, WIN, LOSE) and 3-bit encoding.
//  Shared with the datapath: constants NATURAL_SUMS, CRAPS_SUMS.
//  Sub-module sat_counter #(W) (clr, inc, q): instantiated for win_cnt, lose_cnt, streak, point_rolls.
//  FSM, edge detect and output decode stay in this module.
// TESTING
//  1 enter rise, roll_done with natural=1 -> roll 1 cycle later, then win=1, win_cnt=1, streak=1.
//  2 enter, roll_done with craps=1 -> lose=1, lose_cnt=1, streak=0.
//    Then enter (AUTO_RESTART=1) -> lose=0, roll=1.
//  3 come-out with no flags -> sp pulses exactly 1 cycle.
//    Two plain point rolls, then eq=1 -> win=1, point_rolls=3.
//  4 point phase, seven_out=1 & eq=1 same roll_done -> win=1 (eq priority).
//    Separately, seven_out alone -> lose=1.
//  5 MAX_POINT_ROLLS=2, two plain point rolls -> lose=1 after the 2nd, point_rolls=2.
//  6 reset mid-COME_ROLL while roll=1 -> all outputs 0 immediately. Later roll_done ignored.
//    Holding enter high -> no second game. CNT_W=2: 5 wins -> win_cnt=3 (saturated).

Source files
------------

// File: rtl/craps_pkg.sv
//==============================================================================
// Module : craps_pkg
// Brief  : Shared craps FSM state encoding and dice-sum constants.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package craps_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COME_ROLL  = 3'd1,
    SAVE       = 3'd2,
    POINT_WAIT = 3'd3,
    POINT_ROLL = 3'd4,
    WIN        = 3'd5,
    LOSE       = 3'd6
  } state_t;

  // One bit per dice sum 0..12; bit n set means sum n belongs to the set.
  localparam logic [12:0] NATURAL_SUMS = 13'h0880;
  localparam logic [12:0] CRAPS_SUMS   = 13'h100C;

  function automatic logic sum_in_set(input logic [3:0] sum, input logic [12:0] set);
    return (sum <= 4'd12) ? set[sum] : 1'b0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//==============================================================================
// Module : sat_counter
// Brief  : Up-counter with synchronous clear that holds at its maximum value.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/craps_round_ctrl.sv
//==============================================================================
// Module : craps_round_ctrl
// Brief  : Craps game sequencer with point-roll limit, restart and statistics.
//          Define CRAPS_STREAK_EN to enable the consecutive-win streak counter.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module craps_round_ctrl
  import craps_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int ROLLS_W         = 4,
  parameter int MAX_POINT_ROLLS = 0,
  parameter int AUTO_RESTART    = 1
) (
  input  logic               clk_main,
  input  logic               reset,
  input  logic               enter,
  input  logic               roll_done,
  input  logic               natural,
  input  logic               craps,
  input  logic               seven_out,
  input  logic               eq,
  output logic               roll,
  output logic               sp,
  output logic               win,
  output logic               lose,
  output logic               busy,
  output logic [ROLLS_W-1:0] point_rolls,
  output logic [CNT_W-1:0]   win_cnt,
  output logic [CNT_W-1:0]   lose_cnt,
  output logic [CNT_W-1:0]   streak
);

  localparam logic [ROLLS_W-1:0] c_MAX_ROLLS = ROLLS_W'(MAX_POINT_ROLLS);

  state_t             r_state;
  state_t             w_next;
  logic               r_enter_q;
  logic               w_enter_rise;
  logic [ROLLS_W-1:0] w_rolls_inc;
  logic               w_limit_hit;
  logic               w_rolls_clr;
  logic               w_rolls_step;
  logic               w_win_entry;
  logic               w_lose_entry;

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_enter_q <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_enter_q <= enter;
    end
  end

  assign w_enter_rise = enter & ~r_enter_q;

  // Count the roll being resolved now so the limit applies to this very roll.
  assign w_rolls_inc = (point_rolls == {ROLLS_W{1'b1}}) ? point_rolls : point_rolls + 1'b1;
  assign w_limit_hit = (MAX_POINT_ROLLS != 0) && (w_rolls_inc == c_MAX_ROLLS);

  always_comb begin
    w_next       = r_state;
    w_rolls_clr  = 1'b0;
    w_rolls_step = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_enter_rise) w_next = COME_ROLL;
      end
      COME_ROLL: begin
        if (roll_done) begin
          if (natural)    w_next = WIN;
          else if (craps) w_next = LOSE;
          else            w_next = SAVE;
        end
      end
      SAVE: begin
        w_rolls_clr = 1'b1;
        w_next      = POINT_WAIT;
      end
      POINT_WAIT: begin
        if (w_enter_rise) w_next = POINT_ROLL;
      end
      POINT_ROLL: begin
        if (roll_done) begin
          w_rolls_step = 1'b1;
          if (eq)               w_next = WIN;
          else if (seven_out)   w_next = LOSE;
          else if (w_limit_hit) w_next = LOSE;
          else                  w_next = POINT_WAIT;
        end
      end
      WIN, LOSE: begin
        if ((AUTO_RESTART != 0) && w_enter_rise) begin
          w_next      = COME_ROLL;
          w_rolls_clr = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_win_entry  = (w_next == WIN)  && (r_state != WIN);
  assign w_lose_entry = (w_next == LOSE) && (r_state != LOSE);

  assign roll = (r_state == COME_ROLL) || (r_state == POINT_ROLL);
  assign sp   = (r_state == SAVE);
  assign win  = (r_state == WIN);
  assign lose = (r_state == LOSE);
  assign busy = roll || sp;

  sat_counter #(.W(CNT_W)) u_win_cnt (
    .clk (clk_main),
    .rst (reset),
    .clr (1'b0),
    .inc (w_win_entry),
    .q   (win_cnt)
  );

  sat_counter #(.W(CNT_W)) u_lose_cnt (
    .clk (clk_main),
    .rst (reset),
    .clr (1'b0),
    .inc (w_lose_entry),
    .q   (lose_cnt)
  );

  sat_counter #(.W(ROLLS_W)) u_point_rolls (
    .clk (clk_main),
    .rst (reset),
    .clr (w_rolls_clr),
    .inc (w_rolls_step),
    .q   (point_rolls)
  );

`ifdef CRAPS_STREAK_EN
  sat_counter #(.W(CNT_W)) u_streak (
    .clk (clk_main),
    .rst (reset),
    .clr (w_lose_entry),
    .inc (w_win_entry),
    .q   (streak)
  );
`else
  assign streak = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_craps_round_ctrl.sv
//==============================================================================
// Module : tb_craps_round_ctrl
// Brief  : Randomized self-checking bench for craps_round_ctrl against a
//          game-level reference model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_craps_round_ctrl;

  localparam int CNT_W   = 3;
  localparam int ROLLS_W = 4;
  localparam int MAXR    = 4;
  localparam int SAT     = (1 << CNT_W) - 1;
  localparam int RSAT    = (1 << ROLLS_W) - 1;

  logic               clk_main = 1'b0;
  logic               reset, enter, roll_done, natural, craps, seven_out, eq;
  logic               roll, sp, win, lose, busy;
  logic [ROLLS_W-1:0] point_rolls;
  logic [CNT_W-1:0]   win_cnt, lose_cnt, streak;

  int total = 0;
  int bad   = 0;
  int m_win, m_lose, m_streak, m_rolls;

  craps_round_ctrl #(
    .CNT_W(CNT_W), .ROLLS_W(ROLLS_W), .MAX_POINT_ROLLS(MAXR), .AUTO_RESTART(1)
  ) dut (
    .clk_main(clk_main), .reset(reset), .enter(enter), .roll_done(roll_done),
    .natural(natural), .craps(craps), .seven_out(seven_out), .eq(eq),
    .roll(roll), .sp(sp), .win(win), .lose(lose), .busy(busy),
    .point_rolls(point_rolls), .win_cnt(win_cnt), .lose_cnt(lose_cnt), .streak(streak)
  );

  always #5 clk_main = ~clk_main;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_main);
    #1;
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  function automatic int exp_streak();
`ifdef CRAPS_STREAK_EN
    return m_streak;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_win = 0; m_lose = 0; m_streak = 0; m_rolls = 0;
  endtask

  task automatic record_win();
    m_win    = sat_inc(m_win, SAT);
    m_streak = sat_inc(m_streak, SAT);
  endtask

  task automatic record_lose();
    m_lose   = sat_inc(m_lose, SAT);
    m_streak = 0;
  endtask

  // Busy is expected exactly in the rolling and point-save phases.
  task automatic check_all(input string tag, input bit e_roll, input bit e_sp,
                           input bit e_win, input bit e_lose);
    check({tag, ".roll"},  roll,  e_roll);
    check({tag, ".sp"},    sp,    e_sp);
    check({tag, ".win"},   win,   e_win);
    check({tag, ".lose"},  lose,  e_lose);
    check({tag, ".busy"},  busy,  e_roll | e_sp);
    check({tag, ".prol"},  point_rolls, m_rolls);
    check({tag, ".wcnt"},  win_cnt,  m_win);
    check({tag, ".lcnt"},  lose_cnt, m_lose);
    check({tag, ".strk"},  streak,   exp_streak());
  endtask

  // Dice still tumbling: enter wiggles (ignored while rolling), flags are noise.
  task automatic roll_phase(input string tag);
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      roll_done = 1'b0;
      enter     = 1'($urandom_range(0, 1));
      natural   = 1'($urandom_range(0, 1));
      craps     = 1'($urandom_range(0, 1));
      seven_out = 1'($urandom_range(0, 1));
      eq        = 1'($urandom_range(0, 1));
      step();
      check_all({tag, ".wait"}, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    enter = 1'b0;
  endtask

  task automatic end_hold(input string tag, input bit e_win);
    for (int i = 0; i < 2; i++) begin
      roll_done = 1'($urandom_range(0, 1));
      natural   = 1'($urandom_range(0, 1));
      eq        = 1'($urandom_range(0, 1));
      step();
      check_all({tag, ".hold"}, 1'b0, 1'b0, e_win, !e_win);
    end
    roll_done = 1'b0;
  endtask

  // co: come-out choice (0 none, 1 natural, 2 craps, 3 both, -1 random)
  // pm: point rolls (-1 random, 0 always plain, 1 eq and seven_out together)
  task automatic play_game(input string tag, input int co, input int pm);
    int  c, p;
    bit  done, is_win;
    enter = 1'b1;
    step();
    m_rolls = 0;
    check_all({tag, ".start"}, 1'b1, 1'b0, 1'b0, 1'b0);
    roll_phase(tag);
    c = (co < 0) ? int'($urandom_range(0, 3)) : co;
    natural   = (c == 1) || (c == 3);
    craps     = (c == 2) || (c == 3);
    roll_done = 1'b1;
    step();
    roll_done = 1'b0;
    natural   = 1'($urandom_range(0, 1));
    craps     = 1'($urandom_range(0, 1));
    if (c == 1 || c == 3) begin
      record_win();
      check_all({tag, ".co"}, 1'b0, 1'b0, 1'b1, 1'b0);
      end_hold(tag, 1'b1);
      return;
    end
    if (c == 2) begin
      record_lose();
      check_all({tag, ".co"}, 1'b0, 1'b0, 1'b0, 1'b1);
      end_hold(tag, 1'b0);
      return;
    end
    m_rolls = 0;
    check_all({tag, ".save"}, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_all({tag, ".pwait"}, 1'b0, 1'b0, 1'b0, 1'b0);
    done = 1'b0;
    is_win = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        roll_done = 1'b1; eq = 1'b1; seven_out = 1'b1;
        step();
        check_all({tag, ".stray"}, 1'b0, 1'b0, 1'b0, 1'b0);
        roll_done = 1'b0;
      end
      enter = 1'b1;
      step();
      check_all({tag, ".proll"}, 1'b1, 1'b0, 1'b0, 1'b0);
      roll_phase(tag);
      p = (pm < 0) ? int'($urandom_range(0, 9)) : (pm == 0 ? 9 : 4);
      eq        = (p == 0) || (p == 1) || (p == 4);
      seven_out = (p == 2) || (p == 3) || (p == 4);
      roll_done = 1'b1;
      step();
      roll_done = 1'b0;
      m_rolls = sat_inc(m_rolls, RSAT);
      if (eq) begin
        done = 1'b1; is_win = 1'b1;
      end else if (seven_out || (MAXR != 0 && m_rolls == MAXR)) begin
        done = 1'b1; is_win = 1'b0;
      end
      eq        = 1'($urandom_range(0, 1));
      seven_out = 1'($urandom_range(0, 1));
      if (!done) check_all({tag, ".pnext"}, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (!done) begin
      check({tag, ".bound"}, 32'd0, 32'd1);
      return;
    end
    if (is_win) record_win(); else record_lose();
    check_all({tag, ".pend"}, 1'b0, 1'b0, is_win, !is_win);
    end_hold(tag, is_win);
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; roll_done = 1'b0;
    natural = 1'b0; craps = 1'b0; seven_out = 1'b0; eq = 1'b0;
    model_reset();
    step();
    step();
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    play_game("natural", 1, -1);
    play_game("craps",   2, -1);
    play_game("both",    3, -1);
    play_game("limit",   0,  0);
    play_game("eq7",     0,  1);
    play_game("point",   0, -1);

    // Held enter: one rise starts one game, holding it afterwards does nothing.
    enter = 1'b1;
    step();
    m_rolls = 0;
    check_all("held.start", 1'b1, 1'b0, 1'b0, 1'b0);
    natural = 1'b1; craps = 1'b0; roll_done = 1'b1;
    step();
    roll_done = 1'b0; natural = 1'b0;
    record_win();
    for (int i = 0; i < 4; i++) begin
      step();
      check_all("held.keep", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    enter = 1'b0;
    step();
    check_all("held.rel", 1'b0, 1'b0, 1'b1, 1'b0);

    for (int g = 0; g < 40; g++) play_game("rand", -1, -1);

    // Asynchronous reset in the middle of a come-out roll.
    enter = 1'b1;
    step();
    enter = 1'b0;
    m_rolls = 0;
    check_all("abort.roll", 1'b1, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("abort.async", 1'b0, 1'b0, 1'b0, 1'b0);
    natural = 1'b1; roll_done = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    check_all("abort.ignored", 1'b0, 1'b0, 1'b0, 1'b0);
    roll_done = 1'b0; natural = 1'b0;
    step();
    play_game("post", 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
